// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer blocks: pointer-width rule
// and width-agnostic binary/Gray conversions.
package fifo_pkg;

  // Pointers carry one bit beyond the address so full and empty differ.
  localparam int PTR_EXTRA_BITS = 1;

  // Widest pointer the conversion helpers handle; callers zero-extend.
  localparam int GRAY_MAX_W = 32;

  function automatic int ptr_w(input int addr_w);
    return addr_w + PTR_EXTRA_BITS;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    logic [GRAY_MAX_W-1:0] g;
    g[GRAY_MAX_W-1] = b[GRAY_MAX_W-1];
    for (int i = 0; i < GRAY_MAX_W-1; i++)
      g[i] = b[i] ^ b[i+1];
    return g;
  endfunction

  // Zero-extended upper bits stay zero, so any width up to GRAY_MAX_W works.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/wr_ptr_full_if.sv
// Write-side bundle between the producer and the FIFO write pointer block.
interface wr_ptr_full_if #(
  parameter int ADDR_W = 4
) ();

  logic              i_wrEn;
  logic [ADDR_W:0]   i_syncRdPtrGray;
  logic              i_clrErr;
  logic              o_wrAccept;
  logic [ADDR_W-1:0] o_wrAddr;
  logic [ADDR_W:0]   o_wrPtrGray;
  logic              o_full;
  logic              o_almostFull;
  logic              o_overflow;

  modport master (
    output i_wrEn, i_syncRdPtrGray, i_clrErr,
    input  o_wrAccept, o_wrAddr, o_wrPtrGray, o_full, o_almostFull, o_overflow
  );

  modport slave (
    input  i_wrEn, i_syncRdPtrGray, i_clrErr,
    output o_wrAccept, o_wrAddr, o_wrPtrGray, o_full, o_almostFull, o_overflow
  );

endinterface

// File: rtl/gray_cnt.sv
// Binary + Gray registered pointer with increment enable; shared by the
// write and read pointer blocks.
module gray_cnt
  import fifo_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-2:0] addr_o,
  output logic [W-1:0] gray_o,
  output logic [W-1:0] bin_next_o,
  output logic [W-1:0] gray_next_o
);

  logic [W-1:0] bin_q, bin_d;
  logic [W-1:0] gray_q, gray_d;

  always_comb begin
    bin_d  = bin_q + W'(inc_i);
    gray_d = W'(bin2gray(GRAY_MAX_W'(bin_d)));
  end

  // Gray is registered straight from the next-state value so the output
  // flop has no logic behind it for the crossing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  assign addr_o      = bin_q[W-2:0];
  assign gray_o      = gray_q;
  assign bin_next_o  = bin_d;
  assign gray_next_o = gray_d;

endmodule

// File: rtl/wr_ptr_full.sv
// Write-domain pointer and status generator for the dual-clock FIFO:
// RAM write address/enable, Gray pointer for sync, full/almost-full/overflow.
module wr_ptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int ALMOST_FULL_TH = 12
) (
  input  logic         i_clk,
  input  logic         i_rst,
  wr_ptr_full_if.slave bus
);

  localparam int PTR_W = ptr_w(ADDR_W);

  // Full when the write Gray equals the read Gray with its top two bits flipped.
  localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (ADDR_W-1);
  localparam logic [PTR_W-1:0] AF_TH     = PTR_W'(ALMOST_FULL_TH);

  logic              wrAccept;
  logic [ADDR_W-1:0] wrAddr;
  logic [PTR_W-1:0]  wrGray_q;
  logic [PTR_W-1:0]  wrBinNext;
  logic [PTR_W-1:0]  wrGrayNext;
  logic [PTR_W-1:0]  rdBin;
  logic [PTR_W-1:0]  level;

  logic full_q, full_d;
  logic almostFull_q, almostFull_d;
  logic overflow_q, overflow_d;

  // Reset gating keeps the RAM write enable quiet while the pointer is held.
  assign wrAccept = bus.i_wrEn & ~full_q & ~i_rst;

  gray_cnt #(.W(PTR_W)) u_wr_cnt (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .inc_i       (wrAccept),
    .addr_o      (wrAddr),
    .gray_o      (wrGray_q),
    .bin_next_o  (wrBinNext),
    .gray_next_o (wrGrayNext)
  );

  always_comb begin
    rdBin        = PTR_W'(gray2bin(GRAY_MAX_W'(bus.i_syncRdPtrGray)));
    level        = wrBinNext - rdBin;
    full_d       = (wrGrayNext == (bus.i_syncRdPtrGray ^ FULL_MASK));
    almostFull_d = (level >= AF_TH);
    overflow_d   = (bus.i_wrEn & full_q) | (overflow_q & ~bus.i_clrErr);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      full_q       <= 1'b0;
      almostFull_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      full_q       <= full_d;
      almostFull_q <= almostFull_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.o_wrAccept   = wrAccept;
  assign bus.o_wrAddr     = wrAddr;
  assign bus.o_wrPtrGray  = wrGray_q;
  assign bus.o_full       = full_q;
  assign bus.o_almostFull = almostFull_q;
  assign bus.o_overflow   = overflow_q;

endmodule

// File: tb/tb_wr_ptr_full.sv
// Self-checking bench for wr_ptr_full against a count-based FIFO model.
module tb_wr_ptr_full;

  localparam int ADDR_W = 4;
  localparam int TH     = 12;
  localparam int DEPTH  = 16;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  wr_ptr_full_if #(.ADDR_W(ADDR_W)) bus ();

  wr_ptr_full #(.ADDR_W(ADDR_W), .ALMOST_FULL_TH(TH)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: writes accepted and read position as plain counts mod 32.
  int m_w, m_rd;
  bit m_full, m_af, m_ovf;
  bit acc_seen, acc_exp;

  function automatic logic [11:0] exp_vec();
    int g;
    g = m_w ^ (m_w >> 1);
    return {4'(m_w % DEPTH), 5'(g), m_full, m_af, m_ovf};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {bus.o_wrAddr, bus.o_wrPtrGray, bus.o_full, bus.o_almostFull, bus.o_overflow};
  endfunction

  task automatic model_reset();
    m_w = 0; m_rd = 0; m_full = 0; m_af = 0; m_ovf = 0;
  endtask

  task automatic step(input bit we, input int rdb, input bit clr);
    int lvl;
    @(negedge i_clk);
    bus.i_wrEn          = we;
    bus.i_syncRdPtrGray = 5'((rdb ^ (rdb >> 1)) & 31);
    bus.i_clrErr        = clr;
    #1;
    acc_seen = bus.o_wrAccept;
    acc_exp  = we && !m_full;
    @(posedge i_clk);
    m_ovf  = (we && m_full) || (m_ovf && !clr);
    m_rd   = rdb & 31;
    m_w    = (m_w + (acc_exp ? 1 : 0)) & 31;
    lvl    = (m_w - m_rd) & 31;
    m_full = (lvl == DEPTH);
    m_af   = (lvl >= TH);
    #1;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    bus.i_wrEn = 1'b0; bus.i_clrErr = 1'b0; bus.i_syncRdPtrGray = '0;
    @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    bus.i_wrEn = 1'b1; bus.i_clrErr = 1'b0; bus.i_syncRdPtrGray = '0;
    @(posedge i_clk); #1;
    n_tests++;
    if ({dut_vec(), bus.o_wrAccept} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset: outputs %h wrAccept %b, required all 0", dut_vec(), bus.o_wrAccept);
    end
    @(negedge i_clk);
    i_rst = 1'b0; bus.i_wrEn = 1'b0;
    model_reset();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 0, 1'b0);
      n_tests++;
      if (acc_seen !== 1'b1 || dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL fill w%0d: acc %b vec %h, required acc 1 vec %h", i, acc_seen, dut_vec(), exp_vec());
      end
      if (i == 11 || i == 12) begin
        n_tests++;
        if (bus.o_almostFull !== (i == 12)) begin
          n_fail++;
          $display("FAIL fill_af w%0d: almostFull %b, required %b", i, bus.o_almostFull, i == 12);
        end
      end
      if (i == 15 || i == 16) begin
        n_tests++;
        if (bus.o_full !== (i == 16)) begin
          n_fail++;
          $display("FAIL fill_full w%0d: full %b, required %b", i, bus.o_full, i == 16);
        end
      end
    end
    n_tests++;
    if (bus.o_wrPtrGray !== 5'b11000 || bus.o_wrAddr !== 4'd0) begin
      n_fail++;
      $display("FAIL fill_ptr: gray %b addr %0d, required 11000 addr 0", bus.o_wrPtrGray, bus.o_wrAddr);
    end
  endtask

  task automatic test_overflow();
    step(1'b1, 0, 1'b0);
    n_tests++;
    if (acc_seen !== 1'b0 || bus.o_wrPtrGray !== 5'b11000 || bus.o_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: acc %b gray %b ovf %b, required 0 11000 1", acc_seen, bus.o_wrPtrGray, bus.o_overflow);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 0, 1'b0);
      n_tests++;
      if (bus.o_overflow !== 1'b1 || dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL ovf_sticky c%0d: vec %h, required %h", i, dut_vec(), exp_vec());
      end
    end
    step(1'b1, 0, 1'b1);
    n_tests++;
    if (bus.o_overflow !== 1'b1 || acc_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_set_wins: ovf %b acc %b, required 1 0", bus.o_overflow, acc_seen);
    end
    step(1'b0, 0, 1'b1);
    n_tests++;
    if (bus.o_overflow !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL ovf_clear: vec %h, required %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_release();
    step(1'b0, 1, 1'b0);
    n_tests++;
    if (bus.o_full !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL release: vec %h, required %h (full 0)", dut_vec(), exp_vec());
    end
    step(1'b1, 1, 1'b0);
    n_tests++;
    if (acc_seen !== 1'b1 || bus.o_full !== 1'b1 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL release_refill: acc %b vec %h, required acc 1 vec %h", acc_seen, dut_vec(), exp_vec());
    end
    // Write and freeing read together while full: rejected, then retry lands.
    step(1'b1, 2, 1'b0);
    n_tests++;
    if (acc_seen !== 1'b0 || bus.o_overflow !== 1'b1 || bus.o_full !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle: acc %b ovf %b full %b, required 0 1 0", acc_seen, bus.o_overflow, bus.o_full);
    end
    step(1'b1, 2, 1'b1);
    n_tests++;
    if (acc_seen !== 1'b1 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL retry: acc %b vec %h, required acc 1 vec %h", acc_seen, dut_vec(), exp_vec());
    end
  endtask

  task automatic test_wrap();
    logic [4:0] prev;
    int wraps, bad_steps, bad_vec, full_seen;
    do_reset();
    prev = bus.o_wrPtrGray;
    wraps = 0; bad_steps = 0; bad_vec = 0; full_seen = 0;
    for (int i = 0; i < 80; i++) begin
      step(1'b1, (m_w - 4) & 31, 1'b0);
      if ($countones(bus.o_wrPtrGray ^ prev) > 1) bad_steps++;
      if (prev == 5'b10000 && bus.o_wrPtrGray == 5'b00000) wraps++;
      if (bus.o_full !== 1'b0) full_seen++;
      if (dut_vec() !== exp_vec() || acc_seen !== 1'b1) bad_vec++;
      prev = bus.o_wrPtrGray;
    end
    n_tests++;
    if (bad_steps != 0 || full_seen != 0 || bad_vec != 0) begin
      n_fail++;
      $display("FAIL wrap_stream: multi-bit steps %0d full cycles %0d model diffs %0d, required 0 0 0", bad_steps, full_seen, bad_vec);
    end
    n_tests++;
    if (wraps != 2) begin
      n_fail++;
      $display("FAIL wrap_count: 10000->00000 seen %0d times, required 2", wraps);
    end
  endtask

  task automatic test_random();
    int lvl, adv;
    bit we, clr;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      we  = ($urandom % 4) != 0;
      clr = ($urandom % 8) == 0;
      lvl = (m_w - m_rd) & 31;
      adv = (($urandom % 3) == 0) ? int'($urandom_range(lvl, 0)) : 0;
      step(we, (m_rd + adv) & 31, clr);
      n_tests++;
      if (acc_seen !== acc_exp || dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random c%0d: acc %b vec %h, required acc %b vec %h", i, acc_seen, dut_vec(), acc_exp, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 0, 1'b0);
    n_tests++;
    if (bus.o_wrAddr !== 4'd7) begin
      n_fail++;
      $display("FAIL mid_prefill: addr %0d, required 7", bus.o_wrAddr);
    end
    @(negedge i_clk);
    i_rst = 1'b1; bus.i_wrEn = 1'b1;
    @(posedge i_clk); #1;
    n_tests++;
    if ({dut_vec(), bus.o_wrAccept} !== 13'h0) begin
      n_fail++;
      $display("FAIL mid_reset: outputs %h wrAccept %b, required all 0", dut_vec(), bus.o_wrAccept);
    end
    @(negedge i_clk);
    i_rst = 1'b0; bus.i_wrEn = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (bus.o_wrAddr !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_addr: addr %0d before first write, required 0", bus.o_wrAddr);
    end
    step(1'b1, 0, 1'b0);
    n_tests++;
    if (acc_seen !== 1'b1 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL mid_write: acc %b vec %h, required acc 1 vec %h", acc_seen, dut_vec(), exp_vec());
    end
  endtask

  initial begin
    bus.i_wrEn = 1'b0; bus.i_clrErr = 1'b0; bus.i_syncRdPtrGray = '0;
    model_reset();
    test_reset();
    test_fill();
    test_overflow();
    test_release();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
